// File: rtl/nids_axil_master.sv
// nids_axil_master: single-outstanding command-to-AXI-Lite bridge.
// Accepts one read or write command, runs it on the AXI-Lite master
// channels and returns one response. At most one transaction is in flight.
//
// Optional feature macro: NIDS_AXIL_MST_TIMEOUT_EN. When defined, a watchdog
// aborts a stalled bus transaction after TIMEOUT_CYCLES busy cycles and
// reports rsp_resp=2'b11. When undefined the FSM waits indefinitely.
//
// Ports
//   fpga_clk, fpga_rst_n          clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command request
//   rsp_valid/ready/rdata/resp               command response
//   m_aw*, m_w*, m_b*, m_ar*, m_r*           AXI-Lite master channels
module nids_axil_master #(
  parameter int unsigned ADDR_W         = 21,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  // Elaboration-time parameter sanity check
  if (TIMEOUT_CYCLES == 0 || ADDR_W < 3) begin : g_bad_params
    $error("nids_axil_master: TIMEOUT_CYCLES must be nonzero and ADDR_W >= 3");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_e;

  state_e state, state_nx;

  logic              cmd_ready_nx;
  logic              rsp_valid_nx;
  logic [31:0]       rsp_rdata_nx;
  logic [1:0]        rsp_resp_nx;
  logic [ADDR_W-1:0] m_awaddr_nx;
  logic              m_awvalid_nx;
  logic [31:0]       m_wdata_nx;
  logic [3:0]        m_wstrb_nx;
  logic              m_wvalid_nx;
  logic              m_bready_nx;
  logic [ADDR_W-1:0] m_araddr_nx;
  logic              m_arvalid_nx;
  logic              m_rready_nx;

  logic              busy_c;
  logic              tmo_hit_c;
  logic              accept_c;

  assign accept_c = cmd_valid && cmd_ready;
  assign busy_c   = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);

`ifdef NIDS_AXIL_MST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Busy-cycle watchdog, restarted by each accepted command
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      tmo_cnt <= '0;
    end else if (accept_c) begin
      tmo_cnt <= '0;
    end else if (busy_c) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit_c = busy_c && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= cmd_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_resp  <= rsp_resp_nx;
      m_awaddr  <= m_awaddr_nx;
      m_awvalid <= m_awvalid_nx;
      m_wdata   <= m_wdata_nx;
      m_wstrb   <= m_wstrb_nx;
      m_wvalid  <= m_wvalid_nx;
      m_bready  <= m_bready_nx;
      m_araddr  <= m_araddr_nx;
      m_arvalid <= m_arvalid_nx;
      m_rready  <= m_rready_nx;
    end
  end

  // Next-state and next-output logic; outputs hold unless a transition changes them
  always_comb begin
    state_nx     = state;
    cmd_ready_nx = 1'b0;
    rsp_valid_nx = rsp_valid;
    rsp_rdata_nx = rsp_rdata;
    rsp_resp_nx  = rsp_resp;
    m_awaddr_nx  = m_awaddr;
    m_awvalid_nx = m_awvalid;
    m_wdata_nx   = m_wdata;
    m_wstrb_nx   = m_wstrb;
    m_wvalid_nx  = m_wvalid;
    m_bready_nx  = m_bready;
    m_araddr_nx  = m_araddr;
    m_arvalid_nx = m_arvalid;
    m_rready_nx  = m_rready;

    case (state)
      IDLE: begin
        cmd_ready_nx = 1'b1;
        if (accept_c) begin
          cmd_ready_nx = 1'b0;
          if (cmd_write) begin
            state_nx     = WR;
            m_awaddr_nx  = cmd_addr & ~ADDR_W'(3);
            m_wdata_nx   = cmd_wdata;
            m_wstrb_nx   = cmd_wstrb;
            m_awvalid_nx = 1'b1;
            m_wvalid_nx  = 1'b1;
          end else begin
            state_nx     = RD_A;
            m_araddr_nx  = cmd_addr & ~ADDR_W'(3);
            m_arvalid_nx = 1'b1;
          end
        end
      end

      // AW and W complete independently; leave once both are done
      WR: begin
        m_awvalid_nx = m_awvalid && !m_awready;
        m_wvalid_nx  = m_wvalid && !m_wready;
        if (!m_awvalid_nx && !m_wvalid_nx) begin
          state_nx    = WR_B;
          m_bready_nx = 1'b1;
        end
      end

      WR_B: begin
        if (m_bvalid) begin
          state_nx     = RSP;
          m_bready_nx  = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = '0;
          rsp_resp_nx  = m_bresp;
        end
      end

      RD_A: begin
        if (m_arready) begin
          state_nx     = RD_R;
          m_arvalid_nx = 1'b0;
          m_rready_nx  = 1'b1;
        end
      end

      RD_R: begin
        if (m_rvalid) begin
          state_nx     = RSP;
          m_rready_nx  = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = m_rdata;
          rsp_resp_nx  = m_rresp;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          cmd_ready_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Watchdog abort overrides any bus progress in the same cycle
    if (tmo_hit_c) begin
      state_nx     = RSP;
      m_awvalid_nx = 1'b0;
      m_wvalid_nx  = 1'b0;
      m_bready_nx  = 1'b0;
      m_arvalid_nx = 1'b0;
      m_rready_nx  = 1'b0;
      rsp_valid_nx = 1'b1;
      rsp_rdata_nx = '0;
      rsp_resp_nx  = 2'b11;
    end
  end

endmodule
